alu_out_sel: RTL
================

ALU_OUT_SEL -- requirements
Module: alu_out_sel

Interface
REQ-001 Parameter WIDTH, default 8: width of every result operand and of o_q.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles per scanner step, minimum 1.
REQ-003 Parameter LED_W, fixed as WIDTH+2: width of led.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  sel/res_bus/flags qualify this cycle.
REQ-007 sel  input  4  operation code: 0 add, 1 sub, 2 x2, 3 /2, 4 and, 5 or, 6 xor, 7 not, 8 eq, 9 gt, 10 lt, 11 max, 12 scanner, 13-15 reserved.
REQ-008 res_bus  input  12*WIDTH  result of operation k at bits [k*WIDTH +: WIDTH], k=0..11.
REQ-009 flags  input  4  bit0 add carry, bit1 sub borrow, bit2 x2 carry, bit3 /2 remainder.
REQ-010 o_q  output  WIDTH  registered selected result.
REQ-011 led  output  LED_W  registered LED image.
REQ-012 mul_dp, div_dp  output  1 each  registered active-low decimal points.
REQ-013 out_valid  output  1  one-cycle pulse: o_q/led/dp updated from an accepted request.
REQ-014 sticky_ovf  output  1  sticky carry/borrow indicator (present only per REQ-030).

Function
REQ-015 Request accepted on any rising edge with in_valid=1 and reset=0; latency 1 cycle to o_q/led/dp/out_valid.
REQ-016 Without an accepted request, o_q, mul_dp, div_dp hold; led holds except in scanner mode; out_valid=0.
REQ-017 sel 0-3: o_q=res slice; led[WIDTH-1:0]=o_q, led[WIDTH]=0, led[WIDTH+1]=flags[sel].
REQ-018 sel 2: mul_dp=~flags[2]; sel 3: div_dp=~flags[3]; all other accepted sel: both dp=1.
REQ-019 sel 4-11: o_q=res slice, led[WIDTH-1:0]=o_q across full width, led[WIDTH+1:WIDTH]=00.
REQ-020 sel 12: o_q=0; scanner mode entered; led driven by scanner only.
REQ-021 sel 13-15: request accepted, out_valid pulses, o_q/led/dp hold, scanner mode left.
REQ-022 Scanner state machine: IDLE, LEFT, RIGHT; position pos 0..LED_W-1; prescaler 0..SCAN_DIV-1.
REQ-023 Entry to scanner (sel 12 accepted while not in LEFT/RIGHT): pos=0, prescaler=0, state=LEFT, led=one-hot bit 0 on the accept edge.
REQ-024 sel 12 accepted while already LEFT/RIGHT: no restart; scanner continues, out_valid pulses.
REQ-025 In LEFT/RIGHT prescaler increments each cycle; at SCAN_DIV-1 it wraps to 0 and pos steps (LEFT +1, RIGHT -1).
REQ-026 Bounce: LEFT reaching pos=LED_W-1 switches to RIGHT; RIGHT reaching pos=0 switches to LEFT; no pos outside range, no repeated endpoint.
REQ-027 led in scanner = one-hot at pos, updated same edge as pos.
REQ-028 Any accepted sel other than 12 returns scanner to IDLE; that sel's led image wins on the same edge.

Reset
REQ-029 reset=1 on a rising edge: o_q=0, led=0, mul_dp=1, div_dp=1, out_valid=0, sticky_ovf=0, state=IDLE, pos=0, prescaler=0; overrides in_valid and any scanner step in progress.

Configuration
REQ-030 Macro ALU_OUT_SEL_STICKY_EN defined: sticky_ovf sets when accepted sel 0/1/2 with its flag=1, clears only on reset or accepted sel 0/1/2 with flag=0 following an accepted sel 4; undefined: sticky_ovf port absent, no related logic.

Verification (WIDTH=8, SCAN_DIV=4)
REQ-031 reset, then in_valid=1, sel=0, add slice=8'hF0, flags=4'b0001 -> next cycle o_q=8'hF0, led=10'b10_1111_0000, out_valid=1 one cycle, dp=11.
REQ-032 sel=2, x2 slice=8'h54, flags[2]=1 -> o_q=8'h54, led[9]=1, mul_dp=0, div_dp=1; then sel=5, or slice=8'hA5 -> led=10'b00_1010_0101, mul_dp=1.
REQ-033 sel=12 single accept -> led=10'h001, o_q=0; pos steps every 4 cycles 0..9 then 8..0; led never all-zero, never two bits.
REQ-034 scanner running at pos=6, sel=7, not slice=8'h3C -> next cycle led=10'h03C, state IDLE; later sel=12 restarts at led=10'h001.
REQ-035 reset asserted mid-scan with in_valid=1 -> all outputs to REQ-029 values next edge; sel=14 afterwards -> out_valid=1, outputs unchanged.
REQ-036 STICKY_EN build: sel=1 flags[1]=1 -> sticky_ovf=1; sel=0 flags[0]=0 -> stays 1; sel=4 then sel=0 flags=0 -> sticky_ovf=0.

Source files
------------

// File: rtl/alu_out_sel.sv
// ALU result selector: registers the chosen operation result, builds the LED image and decimal
// points, and runs a bouncing one-hot LED scanner. Optional sticky flag: ALU_OUT_SEL_STICKY_EN.
module alu_out_sel #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [3:0]           sel,
    input  logic [12*WIDTH-1:0]  res_bus,
    input  logic [3:0]           flags,
    output logic [WIDTH-1:0]     o_q,
    output logic [WIDTH+1:0]     led,
    output logic                 mul_dp,
    output logic                 div_dp,
`ifdef ALU_OUT_SEL_STICKY_EN
    output logic                 sticky_ovf,
`endif
    output logic                 out_valid
);

    localparam int unsigned LED_W = WIDTH + 2;
    localparam int unsigned POS_W = $clog2(LED_W);
    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {StIdle, StLeft, StRight} scan_state_e;

    scan_state_e      state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [LED_W-1:0] scan_led;
    logic [WIDTH-1:0] res_slice;
    logic             flag_bit;

    always_comb begin
        res_slice = '0;
        for (int k = 0; k < 12; k++) begin
            if (sel == 4'(k)) res_slice = res_bus[k*WIDTH +: WIDTH];
        end
    end

    assign flag_bit = flags[sel[1:0]];

    // One scanner step; only applied while the scanner is running.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        presc_d = presc_q;
        if (state_q != StIdle) begin
            if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
                presc_d = '0;
                if (state_q == StLeft) begin
                    pos_d = pos_q + 1'b1;
                    if (pos_d == POS_W'(LED_W - 1)) state_d = StRight;
                end else begin
                    pos_d = pos_q - 1'b1;
                    if (pos_d == '0) state_d = StLeft;
                end
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign scan_led = {{(LED_W-1){1'b0}}, 1'b1} << pos_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_q       <= '0;
            led       <= '0;
            mul_dp    <= 1'b1;
            div_dp    <= 1'b1;
            out_valid <= 1'b0;
            state_q   <= StIdle;
            pos_q     <= '0;
            presc_q   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid && sel == 4'd12) begin
                o_q    <= '0;
                mul_dp <= 1'b1;
                div_dp <= 1'b1;
                if (state_q == StIdle) begin
                    state_q <= StLeft;
                    pos_q   <= '0;
                    presc_q <= '0;
                    led     <= {{(LED_W-1){1'b0}}, 1'b1};
                end else begin
                    state_q <= state_d;
                    pos_q   <= pos_d;
                    presc_q <= presc_d;
                    led     <= scan_led;
                end
            end else if (in_valid) begin
                // Any other request stops the scanner; reserved codes leave outputs untouched.
                state_q <= StIdle;
                pos_q   <= '0;
                presc_q <= '0;
                if (sel <= 4'd11) begin
                    o_q    <= res_slice;
                    mul_dp <= ~((sel == 4'd2) & flags[2]);
                    div_dp <= ~((sel == 4'd3) & flags[3]);
                    if (sel <= 4'd3) led <= {flag_bit, 1'b0, res_slice};
                    else             led <= {2'b00, res_slice};
                end
            end else if (state_q != StIdle) begin
                state_q <= state_d;
                pos_q   <= pos_d;
                presc_q <= presc_d;
                led     <= scan_led;
            end
        end
    end

`ifdef ALU_OUT_SEL_STICKY_EN
    logic sticky_q, arm_q;

    // Clearing needs a sel 4 as the immediately preceding accepted request.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= 1'b0;
            arm_q    <= 1'b0;
        end else if (in_valid) begin
            arm_q <= (sel == 4'd4);
            if (sel <= 4'd2) begin
                if (flag_bit)   sticky_q <= 1'b1;
                else if (arm_q) sticky_q <= 1'b0;
            end
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule
